// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush and bubble ctrl.
// Optional stall-cycle perf counter enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
   parameter int unsigned          DATA_W      = 96,
   parameter int unsigned          CTRL_W      = 8,
   parameter logic [CTRL_W-1:0]    CTRL_BUBBLE = {CTRL_W{1'b0}},
   parameter int unsigned          CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  perf_stall_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t              state_r;
   logic                in_ready_r;
   logic                out_valid_r;
   logic [DATA_W-1:0]   main_data_r;
   logic [CTRL_W-1:0]   main_ctrl_r;
   logic [DATA_W-1:0]   skid_data_r;
   logic [CTRL_W-1:0]   skid_ctrl_r;
   logic                accept_s;
   logic                drain_s;

   assign accept_s  = in_valid & in_ready_r;
   assign drain_s   = out_valid_r & out_ready;

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = main_data_r;
   assign out_ctrl  = main_ctrl_r;

   // Stage state machine: main register, skid register and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_EMPTY;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         main_data_r <= {DATA_W{1'b0}};
         main_ctrl_r <= CTRL_BUBBLE;
         skid_data_r <= {DATA_W{1'b0}};
         skid_ctrl_r <= {CTRL_W{1'b0}};
      end else if (flush) begin
         state_r     <= ST_EMPTY;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         main_ctrl_r <= CTRL_BUBBLE;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (accept_s) begin
                  state_r     <= ST_BUSY;
                  out_valid_r <= 1'b1;
                  main_data_r <= in_data;
                  main_ctrl_r <= in_ctrl;
               end else begin
                  state_r     <= ST_EMPTY;
               end
            end
            ST_BUSY: begin
               if (accept_s && drain_s) begin
                  main_data_r <= in_data;
                  main_ctrl_r <= in_ctrl;
               end else if (drain_s) begin
                  state_r     <= ST_EMPTY;
                  out_valid_r <= 1'b0;
                  main_ctrl_r <= CTRL_BUBBLE;
               end else if (accept_s) begin
                  // Downstream stalled: park the new entry behind the one on display.
                  state_r     <= ST_FULL;
                  in_ready_r  <= 1'b0;
                  skid_data_r <= in_data;
                  skid_ctrl_r <= in_ctrl;
               end else begin
                  state_r     <= ST_BUSY;
               end
            end
            ST_FULL: begin
               if (drain_s) begin
                  state_r     <= ST_BUSY;
                  in_ready_r  <= 1'b1;
                  main_data_r <= skid_data_r;
                  main_ctrl_r <= skid_ctrl_r;
               end else begin
                  state_r     <= ST_FULL;
               end
            end
            default: begin
               state_r     <= ST_EMPTY;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               main_ctrl_r <= CTRL_BUBBLE;
            end
         endcase
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_r;

   assign perf_stall_cnt = stall_cnt_r;

   // Saturating count of cycles where a valid entry is held by downstream back-pressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (out_valid_r && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed steps plus random traffic against a queue model.
module tb_pipe_stage_reg;
   localparam int DW = 96;
   localparam int CW = 8;
   localparam int NW = 4;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
   logic [NW-1:0] perf_stall_cnt;
`endif

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(8'h00), .CNT_W(NW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: FIFO of in-flight entries {ctrl,data}, capacity 2.
   logic [CW+DW-1:0] q[$];
   int unsigned      model_cnt;
   int               n_vec;
   int               n_err;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic [CW+DW-1:0] head;
      logic             ev;
      ev   = (q.size() > 0);
      head = ev ? q[0] : '0;
      chk("out_valid", 128'(out_valid), 128'(ev));
      chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
      chk("out_ctrl", 128'(out_ctrl), ev ? 128'(head[CW+DW-1:DW]) : 128'(8'h00));
      if (ev) chk("out_data", 128'(out_data), 128'(head[DW-1:0]));
`ifdef PIPE_STAGE_PERF_EN
      chk("perf_stall_cnt", 128'(perf_stall_cnt), 128'(model_cnt));
`endif
   endtask

   task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic fl);
      logic acc;
      logic drn;
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      flush     = fl;
      #2;
      check_outputs();
      @(posedge clk);
      acc = iv && (q.size() < 2);
      drn = (q.size() > 0) && ordy;
      if ((q.size() > 0) && !ordy && (model_cnt < (2**NW - 1))) model_cnt++;
      if (fl) begin
         q.delete();
      end else begin
         if (drn) void'(q.pop_front());
         if (acc) q.push_back({c, d});
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      q.delete();
      model_cnt = 0;
      chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
      chk("rst_out_ctrl", 128'(out_ctrl), 128'(8'h00));
      chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
      chk("rst_out_data", 128'(out_data), 128'(0));
`ifdef PIPE_STAGE_PERF_EN
      chk("rst_perf", 128'(perf_stall_cnt), 128'(0));
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      model_cnt = 0;
      rst_n = 1'b1;
      flush = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      in_ctrl = '0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Stream 1..10 at full throughput.
      for (int i = 1; i <= 10; i++) cycle(1'b1, DW'(i), CW'(i + 16), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

      // Stall: A held, B captured in skid, then both drain in order.
      cycle(1'b1, 96'hA, 8'hA1, 1'b0, 1'b0);
      cycle(1'b1, 96'hB, 8'hB2, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0);

      // Flush while full with C offered on the same cycle.
      cycle(1'b1, 96'hA, 8'h11, 1'b0, 1'b0);
      cycle(1'b1, 96'hB, 8'h22, 1'b0, 1'b0);
      cycle(1'b1, 96'hC, 8'h33, 1'b0, 1'b1);
      chk("flush_out_valid", 128'(out_valid), 128'(1'b0));
      chk("flush_in_ready", 128'(in_ready), 128'(1'b1));
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

      // Bubble between D and E.
      cycle(1'b1, 96'hD, 8'h44, 1'b1, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      cycle(1'b1, 96'hE, 8'h55, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

      // Reset mid-stream with the skid occupied.
      cycle(1'b1, 96'h1, 8'h66, 1'b0, 1'b0);
      cycle(1'b1, 96'h2, 8'h77, 1'b0, 1'b0);
      do_reset();

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom}, CW'($urandom),
               $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0);
      end

`ifdef PIPE_STAGE_PERF_EN
      // Stall counter saturation with a 4-bit counter.
      do_reset();
      cycle(1'b1, 96'hF, 8'h99, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
      chk("perf_saturate", 128'(perf_stall_cnt), 128'(15));
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
